// File: rtl/my_aes_pkg.sv
// Shared types and constants for the AES-128 round-key expander.
package my_aes_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_EXPAND = 1'b1
  } state_t;

  localparam int NUM_ROUNDS = 10;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational lookup.
module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  // Entry for input 0x00 sits in the top byte, so the bit offset is (255 - in) * 8.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] w_bit_idx;

  assign w_bit_idx = {~i_byte, 3'b000};
  assign o_byte    = SBOX_TBL[w_bit_idx +: 8];

endmodule

// File: rtl/my_aes_key_expand.sv
// AES-128 key schedule: presents round keys 0..10 one at a time over a valid/ready handshake.
//
// state     | meaning
// ST_IDLE   | waiting for start; rk_valid low
// ST_EXPAND | round key r_round presented; advance on each accepted key
module my_aes_key_expand
  import my_aes_pkg::*;
(
  input  logic         clock_clk,
  input  logic         reset_reset,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [3:0]   rk_round,
  output logic [127:0] rk_data,
  output logic         done
);

  state_t       r_state;
  state_t       w_next_state;
  logic [127:0] r_key;
  logic [3:0]   r_round;
  logic         r_done;

  logic         w_load;
  logic         w_advance;
  logic         w_done_nxt;
  logic         w_last;
  logic [3:0]   w_round_inc;
  logic [31:0]  w_w0, w_w1, w_w2, w_w3;
  logic [31:0]  w_rot;
  logic [31:0]  w_sub;
  logic [31:0]  w_t;
  logic [31:0]  w_n0, w_n1, w_n2, w_n3;
  logic [127:0] w_key_nxt;

  assign w_w0 = r_key[127:96];
  assign w_w1 = r_key[95:64];
  assign w_w2 = r_key[63:32];
  assign w_w3 = r_key[31:0];

  assign w_rot = {w_w3[23:0], w_w3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .i_byte (w_rot[8*g +: 8]),
      .o_byte (w_sub[8*g +: 8])
    );
  end

  assign w_round_inc = 4'(r_round + 4'd1);
  assign w_last      = (r_round == 4'(NUM_ROUNDS));

  // RCON is only looked up for rounds 1..10; w_round_inc never exceeds 10 while advancing.
  assign w_t       = w_sub ^ {RCON[w_round_inc], 24'h000000};
  assign w_n0      = w_w0 ^ w_t;
  assign w_n1      = w_w1 ^ w_n0;
  assign w_n2      = w_w2 ^ w_n1;
  assign w_n3      = w_w3 ^ w_n2;
  assign w_key_nxt = {w_n0, w_n1, w_n2, w_n3};

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_advance    = 1'b0;
    w_done_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load       = 1'b1;
          w_next_state = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        if (rk_ready) begin
          if (w_last) begin
            w_next_state = ST_IDLE;
            w_done_nxt   = 1'b1;
          end else begin
            w_advance = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock_clk) begin
    if (reset_reset) begin
      r_state <= ST_IDLE;
      r_key   <= '0;
      r_round <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_done  <= w_done_nxt;
      if (w_load) begin
        r_key   <= key_in;
        r_round <= '0;
      end else if (w_advance) begin
        r_key   <= w_key_nxt;
        r_round <= w_round_inc;
      end
    end
  end

  assign busy     = (r_state == ST_EXPAND);
  assign rk_valid = (r_state == ST_EXPAND);
  assign rk_round = r_round;
  assign rk_data  = r_key;
  assign done     = r_done;

endmodule

// File: tb/tb_my_aes_key_expand.sv
// Self-checking bench: FIPS-197 key schedule model built from GF(2^8) arithmetic, checked every cycle.
module tb_my_aes_key_expand;

  localparam logic [127:0] KEY_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1_FIPS  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K10_FIPS = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K1_ZERO  = 128'h62636363626363636263636362636363;

  logic         clock_clk = 1'b0;
  logic         reset_reset;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [3:0]   rk_round;
  logic [127:0] rk_data;
  logic         done;

  int n_checks = 0;
  int n_errors = 0;

  my_aes_key_expand dut (
    .clock_clk   (clock_clk),
    .reset_reset (reset_reset),
    .start       (start),
    .key_in      (key_in),
    .busy        (busy),
    .rk_valid    (rk_valid),
    .rk_ready    (rk_ready),
    .rk_round    (rk_round),
    .rk_data     (rk_data),
    .done        (done)
  );

  always #5 clock_clk = ~clock_clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: S-box derived from GF(2^8) inverse + affine map
  logic [7:0] sbox_m [0:255];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] inv = 8'h00;
    if (a != 8'h00) begin
      for (int b = 1; b < 256; b++) begin
        if (gf_mul(a, 8'(b)) == 8'h01) inv = 8'(b);
      end
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_m[tmp[31:24]], sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]]}
              ^ {rc, 24'h000000};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // ---------------- model: transaction-level behaviour
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  logic         m_zero = 1'b1;
  int           m_round = 0;
  logic [127:0] m_keys [0:10];
  logic         cmp_en = 1'b0;

  always @(posedge clock_clk) begin
    if (reset_reset) begin
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
      m_zero  <= 1'b1;
      m_round <= 0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (start) begin
          m_busy  <= 1'b1;
          m_round <= 0;
          m_zero  <= 1'b0;
          for (int r = 0; r <= 10; r++) m_keys[r] <= round_key(key_in, r);
        end
      end else if (rk_ready) begin
        if (m_round == 10) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
        end else begin
          m_round <= m_round + 1;
        end
      end
    end
  end

  always @(negedge clock_clk) begin
    if (cmp_en) begin
      check("busy", 128'(busy), 128'(m_busy));
      check("rk_valid", 128'(rk_valid), 128'(m_busy));
      check("done", 128'(done), 128'(m_done));
      if (m_busy) begin
        check("rk_round", 128'(rk_round), 128'(m_round));
        check("rk_data", rk_data, m_keys[m_round]);
      end else if (m_zero) begin
        check("rk_round_idle", 128'(rk_round), 128'h0);
        check("rk_data_idle", rk_data, 128'h0);
      end
    end
  end

  // ---------------- stimulus helpers (all called at a falling edge)
  task automatic start_key(input logic [127:0] key);
    start  = 1'b1;
    key_in = key;
    @(negedge clock_clk);
    start  = 1'b0;
    key_in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic run_until_done(input bit rnd, output int n, output logic [127:0] k1,
                                output logic [127:0] k10, output bit ok);
    n   = 0;
    ok  = 1'b0;
    k1  = 'x;
    k10 = 'x;
    for (int i = 0; i < 300; i++) begin
      if (rk_valid && rk_round == 4'd1)  k1  = rk_data;
      if (rk_valid && rk_round == 4'd10) k10 = rk_data;
      if (done) begin
        ok = 1'b1;
        break;
      end
      rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clock_clk);
      n++;
    end
    rk_ready = 1'b1;
  endtask

  task automatic wait_round(input logic [3:0] r, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (rk_valid && rk_round == r) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock_clk);
    end
  endtask

  int           cyc;
  bit           ok;
  logic [127:0] k1, k10;

  initial begin
    reset_reset = 1'b1;
    start       = 1'b0;
    key_in      = '0;
    rk_ready    = 1'b0;
    for (int i = 0; i < 256; i++) sbox_m[i] = sbox_calc(8'(i));

    check("model_sbox_00", 128'(sbox_m[8'h00]), 128'h63);
    check("model_sbox_53", 128'(sbox_m[8'h53]), 128'hed);
    check("model_fips_r1", round_key(KEY_FIPS, 1), K1_FIPS);
    check("model_fips_r10", round_key(KEY_FIPS, 10), K10_FIPS);
    check("model_zero_r1", round_key(128'h0, 1), K1_ZERO);

    repeat (2) @(negedge clock_clk);
    cmp_en      = 1'b1;
    reset_reset = 1'b0;
    @(negedge clock_clk);

    // FIPS key, consumer always ready
    rk_ready = 1'b1;
    start_key(KEY_FIPS);
    check("t1_round0", rk_data, KEY_FIPS);
    run_until_done(1'b0, cyc, k1, k10, ok);
    check("t1_done_seen", 128'(ok), 128'h1);
    check("t1_latency", 128'(cyc), 128'd11);
    check("t1_round1", k1, K1_FIPS);
    check("t1_round10", k10, K10_FIPS);
    @(negedge clock_clk);

    // same key with random backpressure
    start_key(KEY_FIPS);
    run_until_done(1'b1, cyc, k1, k10, ok);
    check("t2_done_seen", 128'(ok), 128'h1);
    check("t2_round1", k1, K1_FIPS);
    check("t2_round10", k10, K10_FIPS);
    @(negedge clock_clk);

    // reset mid-expansion, then zero key
    start_key(KEY_FIPS);
    wait_round(4'd5, ok);
    check("t3_reach_r5", 128'(ok), 128'h1);
    reset_reset = 1'b1;
    @(negedge clock_clk);
    reset_reset = 1'b0;
    check("t3_busy_after_rst", 128'(busy), 128'h0);
    check("t3_data_after_rst", rk_data, 128'h0);
    start_key(128'h0);
    run_until_done(1'b0, cyc, k1, k10, ok);
    check("t3_done_seen", 128'(ok), 128'h1);
    check("t3_zero_round1", k1, K1_ZERO);
    @(negedge clock_clk);

    // start with another key at round 3 is ignored
    start_key(KEY_FIPS);
    wait_round(4'd3, ok);
    check("t4_reach_r3", 128'(ok), 128'h1);
    start  = 1'b1;
    key_in = 128'hffeeddccbbaa99887766554433221100;
    @(negedge clock_clk);
    start  = 1'b0;
    run_until_done(1'b0, cyc, k1, k10, ok);
    check("t4_done_seen", 128'(ok), 128'h1);
    check("t4_round10", k10, K10_FIPS);

    // start in the done cycle is accepted
    start_key(128'h0);
    check("t5_busy", 128'(busy), 128'h1);
    check("t5_round", 128'(rk_round), 128'h0);
    check("t5_round0", rk_data, 128'h0);
    run_until_done(1'b0, cyc, k1, k10, ok);
    check("t5_done_seen", 128'(ok), 128'h1);
    check("t5_round1", k1, K1_ZERO);
    @(negedge clock_clk);

    // reset wins over start in the same cycle
    reset_reset = 1'b1;
    start       = 1'b1;
    key_in      = KEY_FIPS;
    @(negedge clock_clk);
    reset_reset = 1'b0;
    start       = 1'b0;
    check("t6_busy", 128'(busy), 128'h0);
    check("t6_data", rk_data, 128'h0);
    repeat (3) @(negedge clock_clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/my_aes_key_expand.md
MY_AES_KEY_EXPAND -- requirements
Module: my_aes_key_expand

Interface
REQ-001 The block SHALL have no parameters; it SHALL support AES-128 only (Nk=4, Nr=10).
REQ-002 clock_clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset_reset  input  1  reset; SHALL be synchronous and active-high.
REQ-004 start  input  1  one-cycle request to begin expansion of key_in.
REQ-005 key_in  input  128  cipher key, word w0 = key_in[127:96], w3 = key_in[31:0]; sampled only when start is accepted.
REQ-006 busy  output  1  high from the cycle after start is accepted until done pulses.
REQ-007 rk_valid  output  1  rk_data/rk_round hold a valid round key.
REQ-008 rk_ready  input  1  consumer accepts the presented round key.
REQ-009 rk_round  output  4  index of the presented round key, 0..10.
REQ-010 rk_data  output  128  round key, same word order as key_in.
REQ-011 done  output  1  one-cycle pulse after round key 10 is accepted.

Function
REQ-012 The FSM SHALL have two states: IDLE and EXPAND.
REQ-013 In IDLE, start=1 SHALL load key_in into the round-key register, set rk_round=0 and enter EXPAND on the next edge.
REQ-014 In EXPAND, rk_valid SHALL be 1 and busy SHALL be 1 in every cycle.
REQ-015 A handshake SHALL occur in a cycle where rk_valid=1 and rk_ready=1; rk_data and rk_round SHALL stay stable while rk_valid=1 and rk_ready=0.
REQ-016 On a handshake with rk_round=r<10, the register SHALL load round key r+1 and rk_round SHALL become r+1 on the next edge; back-to-back handshakes SHALL give one key per cycle.
REQ-017 Round key r+1 SHALL be computed combinationally from round key r: t = SubWord(RotWord(w3)) xor {RCON[r+1],24'h0}; w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
REQ-018 RCON[1..10] SHALL be 01,02,04,08,10,20,40,80,1B,36 (hex).
REQ-019 On the handshake with rk_round=10, the FSM SHALL return to IDLE, and done SHALL be 1 for exactly the following cycle, with rk_valid=0 and busy=0 in that cycle.
REQ-020 start SHALL be ignored while in EXPAND; key_in changes during EXPAND SHALL have no effect.
REQ-021 start asserted in the same cycle as done SHALL be accepted, because the FSM is in IDLE in that cycle.
REQ-022 Latency SHALL be: start accepted at edge N -> round 0 valid after edge N; with rk_ready held high, round 10 SHALL be accepted 11 cycles later.

Reset
REQ-023 reset_reset=1 at an edge SHALL force IDLE, rk_valid=0, busy=0, done=0, rk_round=0 and rk_data=0, including mid-expansion.
REQ-024 Reset SHALL take priority over start and over handshakes in the same cycle.

Structure
REQ-025 Package my_aes_pkg SHALL hold the FSM state enum, the NUM_ROUNDS=10 constant and the RCON table.
REQ-026 The S-box SHALL be a combinational sub-module, aes_sbox (8-bit in, 8-bit out, FIPS-197 table); four instances SHALL form SubWord.
REQ-027 The round-key datapath SHALL use a single 128-bit register and no storage of earlier round keys.

Verification
REQ-028 Start with key_in=2b7e151628aed2a6abf7158809cf4f3c and rk_ready=1 -> round 0 = key_in; round 1 = a0fafe1788542cb123a339392a6c7605; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; done 1 cycle later.
REQ-029 Same key, rk_ready toggled pseudo-randomly -> identical 11-key sequence, outputs stable during stalls, no round skipped or repeated.
REQ-030 Pulse reset_reset while rk_round=5 -> next cycle IDLE, rk_valid=0, rk_data=0; a fresh start with key_in=0 -> round 1 = 62636363626363636263636362636363.
REQ-031 Pulse start with a different key_in at rk_round=3 -> ignored; the sequence still matches the original key.
REQ-032 Assert start in the done cycle with key_in=0 -> accepted; round 0 = 0 on the next cycle.
